// File: rtl/vga_obj_pkg.sv
// vga_obj_pkg: definitions shared by the object-offset arbiter and its register file.
//   N_OBJ / PLAYER_IDX : table size and the player's slot (0..23 are wall row*6+col)
//   obj_wr_t           : one register-file write {idx, hoff, voff}
//   arb_state_t        : arbiter FSM states
package vga_obj_pkg;

    localparam int N_OBJ      = 25;
    localparam int PLAYER_IDX = 24;
    localparam int N_ROW      = 4;
    localparam int N_COL      = 6;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] hoff;
        logic [31:0] voff;
    } obj_wr_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        WINDOW = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/obj_offset_regfile.sv
// obj_offset_regfile: N_OBJ x {hoff, voff} offset registers for the display-compare logic.
//   clk, rst            : system clock, synchronous active-high reset
//   wrEn, wrData        : write strobe and {idx, hoff, voff}; idx >= N_OBJ is ignored
//   wallHoff / wallVoff : entries 0..23 unpacked as [row][col]
//   playerHoff / playerVoff : entry PLAYER_IDX
module obj_offset_regfile
    import vga_obj_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wrEn,
    input  obj_wr_t                       wrData,
    output logic [N_ROW-1:0][N_COL-1:0][31:0] wallHoff,
    output logic [N_ROW-1:0][N_COL-1:0][31:0] wallVoff,
    output logic [31:0]                   playerHoff,
    output logic [31:0]                   playerVoff
);

    logic [N_OBJ-1:0][31:0] hoffQ;
    logic [N_OBJ-1:0][31:0] voffQ;

    // NOTE: this table is reset because the compare logic reads every entry
    // directly; an unreset table would show garbage objects after power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            hoffQ <= '0;
            voffQ <= '0;
        end else if (wrEn && (wrData.idx < 5'(N_OBJ))) begin
            hoffQ[wrData.idx] <= wrData.hoff;
            voffQ[wrData.idx] <= wrData.voff;
        end
    end

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        for (genvar c = 0; c < N_COL; c++) begin : g_col
            assign wallHoff[r][c] = hoffQ[r*N_COL + c];
            assign wallVoff[r][c] = voffQ[r*N_COL + c];
        end
    end

    assign playerHoff = hoffQ[PLAYER_IDX];
    assign playerVoff = voffQ[PLAYER_IDX];

endmodule

// File: rtl/vblank_obj_arbiter.sv
// vblank_obj_arbiter: commits player / scroll object-offset updates only during
// vertical blanking, at most WR_BUDGET per window, one per cycle.
//   clk, rst                          : system clock, synchronous active-high reset
//   vCount                            : current line; blanking when vCount >= V_DISP
//   p_req/p_idx/p_hoff/p_voff         : player request (held until p_gnt or p_err)
//   s_req/s_idx/s_hoff/s_voff         : scroll-engine request (same handshake)
//   p_gnt/p_err, s_gnt/s_err          : one-cycle commit / reject (idx >= N_OBJ) pulses
//   wr_en/wr_idx/wr_hoff/wr_voff      : register-file write port (also drives the local table)
//   in_window, frame_tick, miss_cnt   : window status, window-open pulse, saturating miss count
//   wallHoff/wallVoff/playerHoff/playerVoff : offset table contents for CompareDisp
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the
// player always wins ties and the scroll engine can starve within a window.
module vblank_obj_arbiter
    import vga_obj_pkg::*;
#(
    parameter logic [31:0] V_DISP    = 32'd480,
    parameter int          WR_BUDGET = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] vCount,
    input  logic        p_req,
    input  logic [4:0]  p_idx,
    input  logic [31:0] p_hoff,
    input  logic [31:0] p_voff,
    output logic        p_gnt,
    output logic        p_err,
    input  logic        s_req,
    input  logic [4:0]  s_idx,
    input  logic [31:0] s_hoff,
    input  logic [31:0] s_voff,
    output logic        s_gnt,
    output logic        s_err,
    output logic        wr_en,
    output logic [4:0]  wr_idx,
    output logic [31:0] wr_hoff,
    output logic [31:0] wr_voff,
    output logic        in_window,
    output logic        frame_tick,
    output logic [7:0]  miss_cnt,
    output logic [N_ROW-1:0][N_COL-1:0][31:0] wallHoff,
    output logic [N_ROW-1:0][N_COL-1:0][31:0] wallVoff,
    output logic [31:0] playerHoff,
    output logic [31:0] playerVoff
);

    localparam int BUDGET_W = $clog2(WR_BUDGET + 1);

    arb_state_t          state;
    logic [BUDGET_W-1:0] budget;
    logic                vb;
    logic                vbQ;
    logic                pElig;
    logic                sElig;
    logic                anyWin;
    logic                winScroll;
    logic                commit;
    logic                reject;
    obj_wr_t             winner;

`ifdef ARB_ROUND_ROBIN_EN
    logic                rrScroll;   // 1: scroll wins the next tie
`endif

    assign vb        = (vCount >= V_DISP);
    assign in_window = (state == WINDOW);

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        // A requester that just got gnt/err is skipped for one cycle so a
        // still-held req cannot commit twice.
        pElig  = p_req && !(p_gnt || p_err);
        sElig  = s_req && !(s_gnt || s_err);
        anyWin = pElig || sElig;
`ifdef ARB_ROUND_ROBIN_EN
        winScroll = sElig && (!pElig || rrScroll);
`else
        winScroll = sElig && !pElig;
`endif
        winner = winScroll ? obj_wr_t'{idx: s_idx, hoff: s_hoff, voff: s_voff}
                           : obj_wr_t'{idx: p_idx, hoff: p_hoff, voff: p_voff};
        commit = (state == WINDOW) && anyWin && (winner.idx <  5'(N_OBJ));
        reject = (state == WINDOW) && anyWin && (winner.idx >= 5'(N_OBJ));
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACTIVE;
            budget     <= '0;
            vbQ        <= 1'b0;
            p_gnt      <= 1'b0;
            p_err      <= 1'b0;
            s_gnt      <= 1'b0;
            s_err      <= 1'b0;
            wr_en      <= 1'b0;
            wr_idx     <= '0;
            wr_hoff    <= '0;
            wr_voff    <= '0;
            frame_tick <= 1'b0;
            miss_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rrScroll   <= 1'b0;
`endif
        end else begin
            vbQ        <= vb;
            frame_tick <= 1'b0;
            wr_en      <= commit;
            p_gnt      <= commit && !winScroll;
            s_gnt      <= commit &&  winScroll;
            p_err      <= reject && !winScroll;
            s_err      <= reject &&  winScroll;
            if (commit) begin
                wr_idx  <= winner.idx;
                wr_hoff <= winner.hoff;
                wr_voff <= winner.voff;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (commit || reject) rrScroll <= !winScroll;
`endif
            case (state)
                ACTIVE: begin
                    if (vb && !vbQ) begin
                        state      <= WINDOW;
                        frame_tick <= 1'b1;
                        budget     <= BUDGET_W'(WR_BUDGET);
                    end
                end
                WINDOW: begin
                    if (commit) budget <= budget - BUDGET_W'(1);
                    // vb falling takes precedence over budget exhaustion.
                    if (!vb) begin
                        state <= ACTIVE;
                        if ((p_req || s_req) && (miss_cnt != 8'hFF))
                            miss_cnt <= miss_cnt + 8'd1;
                    end else if (commit && (budget == BUDGET_W'(1))) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!vb) begin
                        state <= ACTIVE;
                        if ((p_req || s_req) && (miss_cnt != 8'hFF))
                            miss_cnt <= miss_cnt + 8'd1;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    obj_offset_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wrEn       (wr_en),
        .wrData     ('{idx: wr_idx, hoff: wr_hoff, voff: wr_voff}),
        .wallHoff   (wallHoff),
        .wallVoff   (wallVoff),
        .playerHoff (playerHoff),
        .playerVoff (playerVoff)
    );

endmodule

// File: tb/tb_vblank_obj_arbiter.sv
// tb_vblank_obj_arbiter: table-driven check of vblank_obj_arbiter (WR_BUDGET = 4)
// plus hand-written sequences for table read-back, miss saturation and reset.
module tb_vblank_obj_arbiter;
    import vga_obj_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] vCount;
    logic        p_req, s_req;
    logic [4:0]  p_idx, s_idx;
    logic [31:0] p_hoff, p_voff, s_hoff, s_voff;
    logic        p_gnt, p_err, s_gnt, s_err;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_hoff, wr_voff;
    logic        in_window, frame_tick;
    logic [7:0]  miss_cnt;
    logic [N_ROW-1:0][N_COL-1:0][31:0] wallHoff, wallVoff;
    logic [31:0] playerHoff, playerVoff;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    vblank_obj_arbiter #(.V_DISP(32'd480), .WR_BUDGET(4)) dut (
        .clk(clk), .rst(rst), .vCount(vCount),
        .p_req(p_req), .p_idx(p_idx), .p_hoff(p_hoff), .p_voff(p_voff),
        .p_gnt(p_gnt), .p_err(p_err),
        .s_req(s_req), .s_idx(s_idx), .s_hoff(s_hoff), .s_voff(s_voff),
        .s_gnt(s_gnt), .s_err(s_err),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_hoff(wr_hoff), .wr_voff(wr_voff),
        .in_window(in_window), .frame_tick(frame_tick), .miss_cnt(miss_cnt),
        .wallHoff(wallHoff), .wallVoff(wallVoff),
        .playerHoff(playerHoff), .playerVoff(playerVoff)
    );

    typedef struct {
        logic        rst;
        logic [31:0] vc;
        logic        pr;
        logic [4:0]  pi;
        logic [31:0] ph;
        logic        sr;
        logic [4:0]  si;
        logic [31:0] sh;
        logic        wen;
        logic [4:0]  widx;
        logic [31:0] wh;
        logic        pg, pe, sg, se, iw, ft;
        logic [7:0]  mc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // voff is derived from hoff so each write carries distinct, predictable data.
    task automatic drive(input vec_t v);
        rst    = v.rst;
        vCount = v.vc;
        p_req  = v.pr;  p_idx = v.pi;  p_hoff = v.ph;  p_voff = v.ph + 32'd1000;
        s_req  = v.sr;  s_idx = v.si;  s_hoff = v.sh;  s_voff = v.sh + 32'd2000;
    endtask

    initial begin
        // rst, vc, pr, pi, ph, sr, si, sh, | wen, widx, wh, pg, pe, sg, se, iw, ft, mc
        // reset state
        vecs.push_back(vec_t'{1, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 0,0, 0});
        vecs.push_back(vec_t'{0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 0,0, 0});
        // single player request: frame_tick, then one write to entry 24
        vecs.push_back(vec_t'{0, 480, 1, 24, 100, 0, 0, 0,  0, 0, 0,   0,0,0,0, 1,1, 0});
        vecs.push_back(vec_t'{0, 481, 1, 24, 100, 0, 0, 0,  1, 24, 100, 1,0,0,0, 1,0, 0});
        vecs.push_back(vec_t'{0, 482, 1, 24, 100, 0, 0, 0,  0, 0, 0,   0,0,0,0, 1,0, 0});
        vecs.push_back(vec_t'{0, 483, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,0, 0});
        // bad scroll index: err pulse, no write, budget kept (3 left)
        vecs.push_back(vec_t'{0, 484, 0, 0, 0,   1, 30, 5,  0, 0, 0,   0,0,0,1, 1,0, 0});
        vecs.push_back(vec_t'{0, 485, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,0, 0});
        // both held: P, S, P, then budget exhausted -> DONE, miss on wrap
        vecs.push_back(vec_t'{0, 486, 1, 3, 300, 1, 7, 700, 1, 3, 300,  1,0,0,0, 1,0, 0});
        vecs.push_back(vec_t'{0, 487, 1, 3, 300, 1, 7, 700, 1, 7, 700,  0,0,1,0, 1,0, 0});
        vecs.push_back(vec_t'{0, 488, 1, 3, 300, 1, 7, 700, 1, 3, 300,  1,0,0,0, 0,0, 0});
        vecs.push_back(vec_t'{0, 489, 1, 3, 300, 1, 7, 700, 0, 0, 0,   0,0,0,0, 0,0, 0});
        vecs.push_back(vec_t'{0, 0,   1, 3, 300, 1, 7, 700, 0, 0, 0,   0,0,0,0, 0,0, 1});
        vecs.push_back(vec_t'{0, 1,   0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 0,0, 1});
        // request during active video waits for the window (479 is still visible)
        vecs.push_back(vec_t'{0, 200, 0, 0, 0,   1, 7, 77,  0, 0, 0,   0,0,0,0, 0,0, 1});
        vecs.push_back(vec_t'{0, 479, 0, 0, 0,   1, 7, 77,  0, 0, 0,   0,0,0,0, 0,0, 1});
        vecs.push_back(vec_t'{0, 480, 0, 0, 0,   1, 7, 77,  0, 0, 0,   0,0,0,0, 1,1, 1});
        vecs.push_back(vec_t'{0, 480, 0, 0, 0,   1, 7, 77,  1, 7, 77,  0,0,1,0, 1,0, 1});
        vecs.push_back(vec_t'{0, 481, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,0, 1});
        vecs.push_back(vec_t'{0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 0,0, 1});
        // tie after a player win: round-robin favours scroll, fixed priority the player
        vecs.push_back(vec_t'{0, 480, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,1, 1});
        vecs.push_back(vec_t'{0, 480, 1, 1, 11,  0, 0, 0,   1, 1, 11,  1,0,0,0, 1,0, 1});
        vecs.push_back(vec_t'{0, 480, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,0, 1});
`ifdef ARB_ROUND_ROBIN_EN
        vecs.push_back(vec_t'{0, 480, 1, 2, 22,  1, 4, 44,  1, 4, 44,  0,0,1,0, 1,0, 1});
`else
        vecs.push_back(vec_t'{0, 480, 1, 2, 22,  1, 4, 44,  1, 2, 22,  1,0,0,0, 1,0, 1});
`endif
        vecs.push_back(vec_t'{0, 480, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 1,0, 1});
        vecs.push_back(vec_t'{0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,   0,0,0,0, 0,0, 1});

        drive(vecs[0]);
        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            check($sformatf("v%0d wr_en", i),      32'(wr_en),      32'(vecs[i].wen));
            check($sformatf("v%0d p_gnt", i),      32'(p_gnt),      32'(vecs[i].pg));
            check($sformatf("v%0d p_err", i),      32'(p_err),      32'(vecs[i].pe));
            check($sformatf("v%0d s_gnt", i),      32'(s_gnt),      32'(vecs[i].sg));
            check($sformatf("v%0d s_err", i),      32'(s_err),      32'(vecs[i].se));
            check($sformatf("v%0d in_window", i),  32'(in_window),  32'(vecs[i].iw));
            check($sformatf("v%0d frame_tick", i), 32'(frame_tick), 32'(vecs[i].ft));
            check($sformatf("v%0d miss_cnt", i),   32'(miss_cnt),   32'(vecs[i].mc));
            if (vecs[i].wen) begin
                check($sformatf("v%0d wr_idx", i),  32'(wr_idx), 32'(vecs[i].widx));
                check($sformatf("v%0d wr_hoff", i), wr_hoff,     vecs[i].wh);
                check($sformatf("v%0d wr_voff", i), wr_voff,
                      vecs[i].wh + (vecs[i].pg ? 32'd1000 : 32'd2000));
            end
        end

        // Offset table contents after the writes above.
        check("tbl player hoff", playerHoff,     32'd100);
        check("tbl player voff", playerVoff,     32'd1100);
        check("tbl idx3 hoff",   wallHoff[0][3], 32'd300);
        check("tbl idx7 hoff",   wallHoff[1][1], 32'd77);
        check("tbl idx7 voff",   wallVoff[1][1], 32'd2077);
        check("tbl idx1 voff",   wallVoff[0][1], 32'd1011);

        // Windows closing with a request pending: miss_cnt climbs then saturates.
        s_req = 1'b1; s_idx = 5'd30; p_req = 1'b0;
        for (int w = 0; w < 300; w++) begin
            vCount = 32'd480; tick();
            vCount = 32'd0;   tick();
            if (w == 9) check("miss after 10 more", 32'(miss_cnt), 32'd11);
        end
        check("miss saturated", 32'(miss_cnt), 32'd255);
        s_req = 1'b0;
        tick();

        // Reset on the edge where a grant would be decided drops the write.
        vCount = 32'd480; tick();
        check("rst seq frame_tick", 32'(frame_tick), 32'd1);
        p_req = 1'b1; p_idx = 5'd5; p_hoff = 32'd55; p_voff = 32'd66; rst = 1'b1;
        tick();
        check("rst wr_en",       32'(wr_en),      32'd0);
        check("rst p_gnt",       32'(p_gnt),      32'd0);
        check("rst in_window",   32'(in_window),  32'd0);
        check("rst frame_tick",  32'(frame_tick), 32'd0);
        check("rst miss_cnt",    32'(miss_cnt),   32'd0);
        check("rst wr_hoff",     wr_hoff,         32'd0);
        check("rst table clear", playerHoff,      32'd0);
        rst = 1'b0; p_req = 1'b0;
        tick();
        check("post-rst reopen", 32'(frame_tick), 32'd1);
        check("post-rst wr_en",  32'(wr_en),      32'd0);
        vCount = 32'd0; tick();
        check("post-rst miss",   32'(miss_cnt),   32'd0);
        check("post-rst idx5",   wallHoff[0][5],  32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
